codon_match_counter: RTL and testbench



---
 rtl/codon_match_counter_pkg.sv | 25 ++
 rtl/codon_match_counter_if.sv | 27 ++
 rtl/codon_match_counter_slot.sv | 104 ++++++++++
 rtl/codon_match_counter.sv | 128 ++++++++++++
 tb/tb_codon_match_counter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/codon_match_counter_pkg.sv
// Shared types for the codon match counter: symbol encoding and FSM states.
package codon_pkg;

    localparam int SYM_BITS = 2;

    typedef logic [SYM_BITS-1:0] sym_t;

    localparam sym_t SYM_A = 2'd0;
    localparam sym_t SYM_C = 2'd1;
    localparam sym_t SYM_G = 2'd2;
    localparam sym_t SYM_T = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MATCH,
        ST_FLUSH,
        ST_DONE
    } state_t;

    function automatic logic can_start(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/codon_match_counter_if.sv
// Codon load stream and gene stream, both valid/ready; master = source, slave = counter.
interface codon_match_counter_if #(
    parameter int SYM_W = 2
);
    logic             cdn_valid;
    logic             cdn_ready;
    logic [SYM_W-1:0] cdn_sym;
    logic             cdn_eol;
    logic             cdn_eof;

    logic             gene_valid;
    logic             gene_ready;
    logic [SYM_W-1:0] gene_sym;
    logic             gene_eof;

    modport master (
        output cdn_valid, cdn_sym, cdn_eol, cdn_eof,
        output gene_valid, gene_sym, gene_eof,
        input  cdn_ready, gene_ready
    );

    modport slave (
        input  cdn_valid, cdn_sym, cdn_eol, cdn_eof,
        input  gene_valid, gene_sym, gene_eof,
        output cdn_ready, gene_ready
    );
endinterface

// File: rtl/codon_match_counter_slot.sv
// One codon slot: symbol store, length, loaded flag, window compare and counter (count lands 1 cycle after hit).
// CODON_MATCH_SAT_EN selects saturating counters with a sticky ovf bit; otherwise counters wrap.
module codon_slot #(
    parameter int MAX_LEN = 8,
    parameter int SYM_W   = 2,
    parameter int CNT_W   = 4,
    localparam int LW     = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [SYM_W-1:0]         wr_sym,
    input  logic                     wr_close,
    input  logic                     cmp_en,
    input  logic [MAX_LEN*SYM_W-1:0] win,
    input  logic [LW-1:0]            fill,
    output logic [CNT_W-1:0]         cnt
`ifdef CODON_MATCH_SAT_EN
    ,
    output logic                     ovf
`endif
);

    logic [SYM_W-1:0] sym_q [MAX_LEN];
    logic [LW-1:0]    len_q;
    logic             loaded_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hit;

    // Codon symbol j pairs with window slot k when j + k + 1 equals the stored length.
    always_comb begin
        hit = loaded_q && (fill >= len_q);
        for (int j = 0; j < MAX_LEN; j++) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                if ((j + k + 1 <= MAX_LEN) && (len_q == LW'(j + k + 1)) &&
                    (sym_q[j] != win[k*SYM_W +: SYM_W])) begin
                    hit = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                sym_q[k] <= '0;
            end
            len_q    <= '0;
            loaded_q <= 1'b0;
        end else if (clr) begin
            len_q    <= '0;
            loaded_q <= 1'b0;
        end else if (wr_en) begin
            // Symbols beyond MAX_LEN are accepted upstream but dropped here.
            if (len_q < LW'(MAX_LEN)) begin
                for (int k = 0; k < MAX_LEN; k++) begin
                    if (len_q == LW'(k)) begin
                        sym_q[k] <= wr_sym;
                    end
                end
                len_q <= len_q + LW'(1);
            end
            if (wr_close) begin
                loaded_q <= 1'b1;
            end
        end
    end

`ifdef CODON_MATCH_SAT_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (cmp_en && hit) begin
            if (cnt_q == {CNT_W{1'b1}}) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign ovf = ovf_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (cmp_en && hit) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`endif

    assign cnt = cnt_q;

endmodule

// File: rtl/codon_match_counter.sv
// Loads up to NUM_CODONS codons, then counts overlapping occurrences in a gene stream; counts land 1 cycle after the completing symbol.
// Ready is a pure function of state (no stalls inside LOAD/MATCH); CODON_MATCH_SAT_EN adds saturating counters and the ovf port.
module codon_match_counter
    import codon_pkg::*;
#(
    parameter int NUM_CODONS = 6,
    parameter int MAX_LEN    = 8,
    parameter int SYM_W      = 2,
    parameter int CNT_W      = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    codon_match_counter_if.slave            bus,
    output logic [NUM_CODONS*CNT_W-1:0]     count,
    output logic [$clog2(NUM_CODONS+1)-1:0] num_loaded,
    output logic                            busy,
    output logic                            done
`ifdef CODON_MATCH_SAT_EN
    ,
    output logic [NUM_CODONS-1:0]           ovf
`endif
);

    localparam int NLW = $clog2(NUM_CODONS + 1);
    localparam int LW  = $clog2(MAX_LEN + 1);

    state_t                   state_q, state_d;
    logic [NLW-1:0]           num_loaded_q;
    logic [LW-1:0]            fill_q, fill_next;
    logic [MAX_LEN*SYM_W-1:0] win_q, win_next;

    logic start_ok, cdn_fire, cdn_close, load_end, gene_fire;

    assign start_ok  = start && can_start(state_q);
    assign cdn_fire  = bus.cdn_valid && bus.cdn_ready;
    assign cdn_close = cdn_fire && (bus.cdn_eol || bus.cdn_eof);
    assign load_end  = cdn_fire && (bus.cdn_eof ||
                       (bus.cdn_eol && (num_loaded_q == NLW'(NUM_CODONS - 1))));
    assign gene_fire = bus.gene_valid && bus.gene_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (load_end) state_d = ST_MATCH;
            ST_MATCH: if (gene_fire && bus.gene_eof) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cdn_ready  = (state_q == ST_LOAD);
        bus.gene_ready = (state_q == ST_MATCH);
        busy           = (state_q == ST_LOAD) || (state_q == ST_MATCH);
        done           = (state_q == ST_DONE);
    end

    // Newest gene symbol sits at window index 0.
    always_comb begin
        win_next = win_q;
        if (gene_fire) begin
            win_next[SYM_W-1:0] = bus.gene_sym;
            for (int k = 1; k < MAX_LEN; k++) begin
                win_next[k*SYM_W +: SYM_W] = win_q[(k-1)*SYM_W +: SYM_W];
            end
        end
        fill_next = fill_q;
        if (gene_fire && (fill_q != LW'(MAX_LEN))) begin
            fill_next = fill_q + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_loaded_q <= '0;
            fill_q       <= '0;
            win_q        <= '0;
        end else if (start_ok) begin
            num_loaded_q <= '0;
            fill_q       <= '0;
            win_q        <= '0;
        end else begin
            if (cdn_close) begin
                num_loaded_q <= num_loaded_q + NLW'(1);
            end
            fill_q <= fill_next;
            win_q  <= win_next;
        end
    end

    assign num_loaded = num_loaded_q;

    // The slot currently being loaded is the one indexed by num_loaded.
    for (genvar i = 0; i < NUM_CODONS; i++) begin : g_slot
        codon_slot #(
            .MAX_LEN (MAX_LEN),
            .SYM_W   (SYM_W),
            .CNT_W   (CNT_W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (start_ok),
            .wr_en    (cdn_fire && (num_loaded_q == NLW'(i))),
            .wr_sym   (bus.cdn_sym),
            .wr_close (bus.cdn_eol || bus.cdn_eof),
            .cmp_en   (gene_fire),
            .win      (win_next),
            .fill     (fill_next),
            .cnt      (count[i*CNT_W +: CNT_W])
`ifdef CODON_MATCH_SAT_EN
            ,
            .ovf      (ovf[i])
`endif
        );
    end

endmodule

// File: tb/tb_codon_match_counter.sv
// Directed bench for codon_match_counter: the driver queues expected results, a monitor checks them when done rises.
module tb_codon_match_counter;
    import codon_pkg::*;

    localparam int NC = 6;
    localparam int ML = 8;
    localparam int SW = 2;
    localparam int CW = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [NC*CW-1:0] count;
    logic [2:0]       num_loaded;
    logic             busy;
    logic             done;
`ifdef CODON_MATCH_SAT_EN
    logic [NC-1:0]    ovf;
`endif

    codon_match_counter_if #(.SYM_W(SW)) bus();

    codon_match_counter #(
        .NUM_CODONS (NC),
        .MAX_LEN    (ML),
        .SYM_W      (SW),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .count      (count),
        .num_loaded (num_loaded),
        .busy       (busy),
        .done       (done)
`ifdef CODON_MATCH_SAT_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [NC*CW-1:0] cnt;
        logic [2:0]    nl;
        logic [NC-1:0] ov;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    logic mon_done_q = 1'b0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout actual=0 required=1", name);
    endtask

    function automatic logic [NC*CW-1:0] pk(input int a, input int b, input int c,
                                            input int d, input int e, input int f);
        return {4'(f), 4'(e), 4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic void expect_run(input string name, input logic [NC*CW-1:0] cnt,
                                       input logic [2:0] nl, input logic [NC-1:0] ov);
        exp_t e;
        e.name = name;
        e.cnt  = cnt;
        e.nl   = nl;
        e.ov   = ov;
        sbq.push_back(e);
    endfunction

    function automatic logic [1:0] enc(input byte c);
        case (c)
            "C":     return SYM_C;
            "G":     return SYM_G;
            "T":     return SYM_T;
            default: return SYM_A;
        endcase
    endfunction

    // Monitor: compares the scoreboard head whenever a run completes.
    initial begin
        forever begin
            @(negedge clk);
            if (done && !mon_done_q) begin
                if (sbq.size() == 0) begin
                    timeout_fail("unexpected_done_without_expectation");
                end else begin
                    mon_e = sbq.pop_front();
                    for (int i = 0; i < NC; i++) begin
                        check($sformatf("%s_count%0d", mon_e.name, i),
                              32'(count[i*CW +: CW]), 32'(mon_e.cnt[i*CW +: CW]));
                    end
                    check($sformatf("%s_num_loaded", mon_e.name), 32'(num_loaded), 32'(mon_e.nl));
`ifdef CODON_MATCH_SAT_EN
                    check($sformatf("%s_ovf", mon_e.name), 32'(ovf), 32'(mon_e.ov));
`endif
                end
            end
            mon_done_q = done;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic cdn_send(input logic [1:0] s, input logic eol, input logic eof);
        int n = 0;
        bus.cdn_valid = 1'b1;
        bus.cdn_sym   = s;
        bus.cdn_eol   = eol;
        bus.cdn_eof   = eof;
        while (!bus.cdn_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cdn_ready) timeout_fail("cdn_ready");
        else @(negedge clk);
        bus.cdn_valid = 1'b0;
        bus.cdn_eol   = 1'b0;
        bus.cdn_eof   = 1'b0;
    endtask

    task automatic gene_send(input logic [1:0] s, input logic eof, input int gap);
        int n = 0;
        bus.gene_valid = 1'b1;
        bus.gene_sym   = s;
        bus.gene_eof   = eof;
        while (!bus.gene_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.gene_ready) timeout_fail("gene_ready");
        else @(negedge clk);
        bus.gene_valid = 1'b0;
        bus.gene_eof   = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic load_codon(input string s, input bit last);
        for (int i = 0; i < s.len(); i++) begin
            cdn_send(enc(s[i]), i == s.len() - 1, last && (i == s.len() - 1));
        end
    endtask

    task automatic gene_str(input string s, input bit eof, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            gene_send(enc(s[i]), eof && (i == s.len() - 1), gap);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) timeout_fail("done");
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cdn_valid  = 1'b0;
        bus.cdn_sym    = '0;
        bus.cdn_eol    = 1'b0;
        bus.cdn_eof    = 1'b0;
        bus.gene_valid = 1'b0;
        bus.gene_sym   = '0;
        bus.gene_eof   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_num_loaded", 32'(num_loaded), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cdn_ready", 32'(bus.cdn_ready), 0);
        check("rst_gene_ready", 32'(bus.gene_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three codons of mixed length.
        expect_run("t1", pk(2, 2, 2, 0, 0, 0), 3'd3, '0);
        do_start();
        check("t1_busy_load", 32'(busy), 1);
        load_codon("AC", 1'b0);
        load_codon("G", 1'b0);
        load_codon("ACG", 1'b1);
        gene_str("ACGACG", 1'b1, 0);
        wait_done();
        check("t1_done", 32'(done), 1);
        check("t1_busy_done", 32'(busy), 0);

        // Overlapping matches; start in MATCH must be ignored.
        expect_run("t2", pk(3, 0, 0, 0, 0, 0), 3'd1, '0);
        do_start();
        check("t2_count_cleared", 32'(count), 0);
        load_codon("AA", 1'b1);
        do_start();
        check("t2_start_ignored_nl", 32'(num_loaded), 1);
        check("t2_start_ignored_gene_ready", 32'(bus.gene_ready), 1);
        gene_str("AAAA", 1'b1, 0);
        wait_done();

        // Counter overflow.
`ifdef CODON_MATCH_SAT_EN
        expect_run("t3", pk(15, 0, 0, 0, 0, 0), 3'd1, 6'b000001);
`else
        expect_run("t3", pk(4, 0, 0, 0, 0, 0), 3'd1, '0);
`endif
        do_start();
        load_codon("A", 1'b1);
        for (int i = 0; i < 20; i++) gene_send(SYM_A, i == 19, 0);
        wait_done();

        // Codon longer than MAX_LEN is truncated to 8 symbols.
        expect_run("t4", pk(1, 0, 0, 0, 0, 0), 3'd1, '0);
        do_start();
        load_codon("ACGTACGTAA", 1'b1);
        gene_str("ACGTACGT", 1'b1, 0);
        wait_done();

        // Idle gene cycles between symbols.
        expect_run("t5", pk(1, 0, 0, 0, 0, 0), 3'd1, '0);
        do_start();
        load_codon("ACG", 1'b1);
        gene_str("ACG", 1'b1, 3);
        wait_done();

        // All six slots via eol only; load stops after the sixth.
        expect_run("t7", pk(2, 2, 0, 0, 2, 1), 3'd6, '0);
        do_start();
        load_codon("A", 1'b0);
        load_codon("C", 1'b0);
        load_codon("G", 1'b0);
        load_codon("T", 1'b0);
        load_codon("AC", 1'b0);
        load_codon("CA", 1'b0);
        check("t7_cdn_ready_closed", 32'(bus.cdn_ready), 0);
        check("t7_gene_ready", 32'(bus.gene_ready), 1);
        gene_str("ACAC", 1'b1, 0);
        wait_done();

        // Asynchronous reset in the middle of MATCH.
        do_start();
        load_codon("A", 1'b1);
        gene_str("AA", 1'b0, 0);
        check("t6_count_before_rst", 32'(count[CW-1:0]), 2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_num_loaded", 32'(num_loaded), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_done", 32'(done), 0);
        check("t6_rst_gene_ready", 32'(bus.gene_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_run("t6", pk(2, 0, 0, 0, 0, 0), 3'd1, '0);
        do_start();
        load_codon("C", 1'b1);
        gene_str("CC", 1'b1, 0);
        wait_done();

        repeat (2) @(negedge clk);
        if (sbq.size() != 0) timeout_fail("scoreboard_drained");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
